pet_feeder_system: RTL and testbench
====================================

# pet_feeder_system

Top-level controller of the pet feeder. It receives single-byte commands on a UART, echoes each byte back, and drives the feed actuator output `led_control`. On every feed command it issues one fixed I2C write transaction. It also provides an activity LED. It sits directly under the board top and owns all external serial pins.

## Interface
- `clk_freq`, default 50_000_000: clock frequency in Hz.
- `uart_baud_rate`, default 57600: UART bit rate.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `led`  out  1  activity LED; toggles on every correctly framed received byte.
- `led_control`  out  1  feed actuator enable.
- `uart_rxd`  in  1  UART receive, 8N1, idle high.
- `uart_txd`  out  1  UART transmit, 8N1, idle high.
- `sda`  inout  1  I2C data, open-drain: drives 0 or releases to `z`. Requires an external pull-up.
- `scl`  out  1  I2C clock, push-pull, idle high.

## Operation
- Bit divisor: `DIV = clk_freq / uart_baud_rate`, integer-truncated (868 at defaults).
- I2C half-period: `HP = clk_freq / 200000` cycles, giving 100 kHz SCL (250 at defaults).
- UART RX:
  - `uart_rxd` passes through a 2-FF synchronizer.
  - A start is detected on a falling edge while idle. The start bit is re-checked at `DIV/2`; if it reads high, it is a glitch and RX returns to idle.
  - Data is sampled LSB first at every `DIV` thereafter.
  - The stop bit must be 1. If it is 0, the byte is discarded: no echo, no `led` toggle, no command effect.
- UART TX:
  - Every valid received byte is echoed: start bit, 8 data bits LSB first, stop bit, each bit `DIV` cycles.
  - A one-byte holding register backs the transmitter. A byte arriving while both the transmitter and the holding register are full is not echoed, but its command still executes.
- Command decode, valid bytes only:
  - 0x46 'F': set `led_control`=1. If the I2C engine is idle, start a transaction; if it is busy, the I2C part is ignored.
  - 0x53 'S': clear `led_control`=0.
  - Any other byte: echo only.
- I2C engine states: IDLE, START, BIT, ACK, STOP.
  - Transaction sequence: START, byte 0xAA (7-bit address 0x55, W=0), ACK slot, byte 0xAA (data), ACK slot, STOP.
  - START: `sda` falls while `scl`=1, then `scl` falls after `HP`.
  - Bits go out MSB first. `sda` changes only while `scl`=0, and each `scl` phase lasts `HP`.
  - ACK slot: `sda` is released and sampled at the `scl` rising edge plus `HP/2`.
  - NACK (1 sampled): jump to STOP, no retry.
  - STOP: `sda`=0 with `scl` rising, then `sda` released `HP` later. After that the engine returns to IDLE.
- Reset mid-operation aborts all activity in the same cycle. Outputs return to their reset values and a partial UART/I2C frame is abandoned.

## Timing
- Reset values: `led`=0, `led_control`=0, `uart_txd`=1, `scl`=1, `sda`=`z`. All FSMs go to idle.
- The byte-valid pulse fires 1 cycle after the stop-bit sample.
- `led` toggle and `led_control` update happen on the cycle after byte-valid.
- The echo start bit begins within 2 cycles of byte-valid.
- The I2C START edge (`sda` falling) occurs within 2 cycles of 'F' decode.
- Full I2C transaction: START + 18 bit/ACK slots × 2·`HP` + STOP ≈ 40·`HP` cycles (~200 µs at defaults).
- Simultaneous 'S' decode and I2C activity: `led_control` clears and the I2C transaction completes.
- Back-to-back RX bytes at full baud are all decoded; none are lost.

## Test plan
- Reset: hold `rst`=1 for 4 cycles, release → `led`=0, `led_control`=0, `uart_txd`=1, `scl`=1, `sda`=`z` (pull-up reads 1).
- Send 0x46 at 57600 baud (50 MHz) → `led` toggles to 1, `led_control`=1, 0x46 echoed on `uart_txd`. I2C traffic observed: START, 0xAA, ACK, 0xAA, ACK, STOP, with SCL period 500 cycles.
- Send 0x53 → `led_control`=0, `led` toggles, 0x53 echoed, no I2C activity.
- Send 0x41 with stop bit forced 0 → no echo, `led` unchanged, `led_control` unchanged.
- Send 0x46 with no I2C slave (NACK via pull-up) → STOP follows the first ACK slot and the data byte is not sent.
- Assert `rst` mid-echo and mid-I2C → next cycle `uart_txd`=1, `scl`=1, `sda`=`z`, `led_control`=0.

Source files
------------

// File: rtl/pet_feeder_system.sv
// Pet feeder top-level controller: UART command receiver with echo, feed actuator
// enable, activity LED, and a fixed two-byte I2C write issued on every feed command.
module pet_feeder_system #(
  parameter int unsigned clk_freq       = 50_000_000,
  parameter int unsigned uart_baud_rate = 57600
) (
  input  logic clk,
  input  logic rst,
  output logic led,
  output logic led_control,
  input  logic uart_rxd,
  output logic uart_txd,
  inout  wire  sda,
  output logic scl
);

  localparam int unsigned Div      = clk_freq / uart_baud_rate;
  localparam int unsigned Hp       = clk_freq / 200000;
  localparam logic [15:0] DivLast  = 16'(Div - 1);
  localparam logic [15:0] HalfLast = 16'(Div / 2 - 1);
  localparam logic [15:0] HpLast   = 16'(Hp - 1);
  localparam logic [15:0] HpHalf   = 16'(Hp / 2);
  localparam logic [7:0]  CmdFeed  = 8'h46;
  localparam logic [7:0]  CmdStop  = 8'h53;
  // 7-bit address 0x55 with W=0, reused as the data byte
  localparam logic [7:0]  I2cByte  = 8'hAA;

  localparam logic [1:0] RxIdle  = 2'd0;
  localparam logic [1:0] RxStart = 2'd1;
  localparam logic [1:0] RxData  = 2'd2;
  localparam logic [1:0] RxStop  = 2'd3;

  localparam logic [2:0] I2cIdle  = 3'd0;
  localparam logic [2:0] I2cStart = 3'd1;
  localparam logic [2:0] I2cBit   = 3'd2;
  localparam logic [2:0] I2cAck   = 3'd3;
  localparam logic [2:0] I2cStop  = 3'd4;

  logic        rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic [1:0]  rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic        rx_valid_q;
  logic        is_feed, is_stop;

  logic        led_q, led_control_q;

  logic        tx_busy_q;
  logic [8:0]  tx_shift_q;
  logic [3:0]  tx_bit_q;
  logic [15:0] tx_cnt_q;
  logic        txd_q;
  logic        hold_full_q;
  logic [7:0]  hold_q;
  logic        tx_end, tx_free;

  logic [2:0]  i2c_state_q;
  logic [15:0] i2c_cnt_q;
  logic [2:0]  i2c_bit_q;
  logic        i2c_byte_q;
  logic        ack_ok_q;
  logic        scl_q, sda_low_q;

  assign led         = led_q;
  assign led_control = led_control_q;
  assign uart_txd    = txd_q;
  assign scl         = scl_q;
  assign sda         = sda_low_q ? 1'b0 : 1'bz;

  assign is_feed = rx_valid_q && (rx_shift_q == CmdFeed);
  assign is_stop = rx_valid_q && (rx_shift_q == CmdStop);

  // Two-flop synchronizer plus a delay stage so the idle receiver can see a falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
      rxd_s3_q <= 1'b1;
    end else begin
      rxd_s1_q <= uart_rxd;
      rxd_s2_q <= rxd_s1_q;
      rxd_s3_q <= rxd_s2_q;
    end
  end

  // Receiver: qualify start at half a bit, then sample once per bit; stop must be high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        RxIdle: begin
          if (!rxd_s2_q && rxd_s3_q) begin
            rx_state_q <= RxStart;
            rx_cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (rx_cnt_q == HalfLast) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rxd_s2_q ? RxIdle : RxData;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RxData: begin
          if (rx_cnt_q == DivLast) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rxd_s2_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RxStop: begin
          if (rx_cnt_q == DivLast) begin
            rx_cnt_q   <= '0;
            rx_valid_q <= rxd_s2_q;
            rx_state_q <= RxIdle;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // Command decode: activity LED toggles per good byte, feed enable set/cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q         <= 1'b0;
      led_control_q <= 1'b0;
    end else if (rx_valid_q) begin
      led_q <= ~led_q;
      if (is_feed) begin
        led_control_q <= 1'b1;
      end else if (is_stop) begin
        led_control_q <= 1'b0;
      end
    end
  end

  assign tx_end  = tx_busy_q && (tx_cnt_q == DivLast) && (tx_bit_q == 4'd9);
  assign tx_free = !tx_busy_q || tx_end;

  // Echo transmitter with a one-byte holding register; a byte that finds both full is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy_q   <= 1'b0;
      tx_shift_q  <= '1;
      tx_bit_q    <= '0;
      tx_cnt_q    <= '0;
      txd_q       <= 1'b1;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      if (tx_busy_q) begin
        if (tx_cnt_q == DivLast) begin
          tx_cnt_q   <= '0;
          tx_bit_q   <= tx_bit_q + 4'd1;
          txd_q      <= tx_shift_q[0];
          tx_shift_q <= {1'b1, tx_shift_q[8:1]};
        end else begin
          tx_cnt_q <= tx_cnt_q + 16'd1;
        end
      end
      // A new frame load takes priority over the end-of-frame return to idle
      if (tx_free && (hold_full_q || rx_valid_q)) begin
        tx_busy_q  <= 1'b1;
        tx_cnt_q   <= '0;
        tx_bit_q   <= '0;
        txd_q      <= 1'b0;
        tx_shift_q <= {1'b1, (hold_full_q ? hold_q : rx_shift_q)};
      end else if (tx_end) begin
        tx_busy_q <= 1'b0;
        txd_q     <= 1'b1;
      end
      if (tx_free && hold_full_q) begin
        hold_full_q <= rx_valid_q;
        hold_q      <= rx_shift_q;
      end else if (!tx_free && rx_valid_q && !hold_full_q) begin
        hold_full_q <= 1'b1;
        hold_q      <= rx_shift_q;
      end
    end
  end

  // I2C write engine; in bit, ack and stop states scl_q doubles as the half-period phase
  always_ff @(posedge clk) begin
    if (rst) begin
      i2c_state_q <= I2cIdle;
      i2c_cnt_q   <= '0;
      i2c_bit_q   <= 3'd7;
      i2c_byte_q  <= 1'b0;
      ack_ok_q    <= 1'b0;
      scl_q       <= 1'b1;
      sda_low_q   <= 1'b0;
    end else begin
      case (i2c_state_q)
        I2cIdle: begin
          if (is_feed) begin
            i2c_state_q <= I2cStart;
            i2c_cnt_q   <= '0;
            sda_low_q   <= 1'b1;
          end
        end
        I2cStart: begin
          if (i2c_cnt_q == HpLast) begin
            i2c_cnt_q   <= '0;
            scl_q       <= 1'b0;
            i2c_bit_q   <= 3'd7;
            i2c_byte_q  <= 1'b0;
            i2c_state_q <= I2cBit;
          end else begin
            i2c_cnt_q <= i2c_cnt_q + 16'd1;
          end
        end
        I2cBit: begin
          if (!scl_q && (i2c_cnt_q == '0)) sda_low_q <= ~I2cByte[i2c_bit_q];
          if (i2c_cnt_q == HpLast) begin
            i2c_cnt_q <= '0;
            scl_q     <= ~scl_q;
            if (scl_q) begin
              if (i2c_bit_q == 3'd0) i2c_state_q <= I2cAck;
              else                   i2c_bit_q   <= i2c_bit_q - 3'd1;
            end
          end else begin
            i2c_cnt_q <= i2c_cnt_q + 16'd1;
          end
        end
        I2cAck: begin
          if (!scl_q && (i2c_cnt_q == '0)) sda_low_q <= 1'b0;
          if (scl_q && (i2c_cnt_q == HpHalf)) ack_ok_q <= !sda;
          if (i2c_cnt_q == HpLast) begin
            i2c_cnt_q <= '0;
            scl_q     <= ~scl_q;
            if (scl_q) begin
              if (!ack_ok_q || i2c_byte_q) begin
                i2c_state_q <= I2cStop;
              end else begin
                i2c_byte_q  <= 1'b1;
                i2c_bit_q   <= 3'd7;
                i2c_state_q <= I2cBit;
              end
            end
          end else begin
            i2c_cnt_q <= i2c_cnt_q + 16'd1;
          end
        end
        I2cStop: begin
          if (!scl_q && (i2c_cnt_q == '0)) sda_low_q <= 1'b1;
          if (i2c_cnt_q == HpLast) begin
            i2c_cnt_q <= '0;
            if (!scl_q) begin
              scl_q <= 1'b1;
            end else begin
              sda_low_q   <= 1'b0;
              i2c_state_q <= I2cIdle;
            end
          end else begin
            i2c_cnt_q <= i2c_cnt_q + 16'd1;
          end
        end
        default: i2c_state_q <= I2cIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pet_feeder_system.sv
// Scoreboard bench for pet_feeder_system: a byte-level command model predicts echoes,
// LED/actuator states and I2C transactions; independent monitors decode the pins.
module tb_pet_feeder_system;

  localparam int unsigned ClkFreq = 4_000_000;
  localparam int unsigned Baud    = 400_000;
  localparam int Div        = ClkFreq / Baud;       // 10 cycles per UART bit
  localparam int Hp         = ClkFreq / 200000;     // 20 cycles per SCL half-period
  localparam int ClkPeriod  = 10;
  localparam int AckTxnLen  = 39 * Hp;
  localparam int NackTxnLen = 21 * Hp;
  localparam int Margin     = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rxd = 1'b1;
  logic led, led_control, uart_txd, scl;
  wire  sda;
  logic slave_drive = 1'b0;

  assign sda = slave_drive ? 1'b0 : 1'bz;
  pullup (sda);

  pet_feeder_system #(
    .clk_freq      (ClkFreq),
    .uart_baud_rate(Baud)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .led        (led),
    .led_control(led_control),
    .uart_rxd   (uart_rxd),
    .uart_txd   (uart_txd),
    .sda        (sda),
    .scl        (scl)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues filled by the stimulus-side model
  logic [7:0] echo_q[$];
  logic [1:0] led_exp_q[$];
  bit         txn_q[$];

  // Command model state
  bit m_led = 1'b0;
  bit m_ctrl = 1'b0;
  int i2c_free_at = -100000;
  bit next_ack = 1'b0;
  bit cur_ack = 1'b0;
  bit mon_on = 1'b0;
  bit in_txn = 1'b0;
  int falls = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT produced output with nothing predicted", name);
  endtask

  // Update the model for one byte, then drive it as an 8N1 frame
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit ack);
    int t_dec;
    if (stop_ok) begin
      if (b == 8'h46) begin
        t_dec = cyc + 9 * Div + Div / 2 + 4;
        if (t_dec > i2c_free_at - Margin && t_dec < i2c_free_at + Margin) begin
          repeat (2 * Margin) @(negedge clk);
          t_dec = cyc + 9 * Div + Div / 2 + 4;
        end
        if (t_dec >= i2c_free_at + Margin) begin
          next_ack = ack;
          txn_q.push_back(ack);
          i2c_free_at = t_dec + (ack ? AckTxnLen : NackTxnLen);
        end
        m_ctrl = 1'b1;
      end else if (b == 8'h53) begin
        m_ctrl = 1'b0;
      end
      m_led = ~m_led;
      led_exp_q.push_back({m_led, m_ctrl});
      echo_q.push_back(b);
    end
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (Div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (Div) @(negedge clk);
    end
    uart_rxd = stop_ok;
    repeat (Div) @(negedge clk);
    uart_rxd = 1'b1;
    if (!stop_ok) repeat (Div) @(negedge clk);
  endtask

  // LED monitor: every activity-LED edge must match the next predicted state
  logic [1:0] led_exp;
  initial forever begin
    @(led);
    #1;
    if (mon_on) begin
      if (led_exp_q.size() == 0) begin
        unexpected("led_toggle");
      end else begin
        led_exp = led_exp_q.pop_front();
        check("led", 32'(led), 32'(led_exp[1]));
        check("led_control", 32'(led_control), 32'(led_exp[0]));
      end
    end
  end

  // Echo monitor: decode each frame on uart_txd
  logic [7:0] echo_d, echo_exp;
  logic       echo_st, echo_sp;
  initial forever begin
    @(negedge uart_txd);
    repeat (Div / 2) @(posedge clk);
    #1 echo_st = uart_txd;
    for (int i = 0; i < 8; i++) begin
      repeat (Div) @(posedge clk);
      #1 echo_d[i] = uart_txd;
    end
    repeat (Div) @(posedge clk);
    #1 echo_sp = uart_txd;
    if (mon_on) begin
      if (echo_q.size() == 0) begin
        unexpected("echo");
      end else begin
        echo_exp = echo_q.pop_front();
        check("echo_data", 32'(echo_d), 32'(echo_exp));
        check("echo_framing", 32'({echo_st, echo_sp}), 32'(2'b01));
      end
    end
  end

  // I2C monitor and slave
  logic [31:0] i2c_bits;
  int          n_bits;
  time         first_rise;
  bit          txn_exp;

  always @(negedge sda) begin
    if (mon_on && scl === 1'b1) begin
      in_txn = 1'b1;
      n_bits = 0;
      i2c_bits = '0;
      falls = 0;
      cur_ack = next_ack;
    end
  end

  always @(posedge scl) begin
    if (mon_on && in_txn) begin
      i2c_bits = {i2c_bits[30:0], sda};
      n_bits++;
      if (n_bits == 1) first_rise = $time;
      if (n_bits == 2) check("scl_period", 32'($time - first_rise), 32'(2 * Hp * ClkPeriod));
    end
  end

  // Slave acknowledges during the 9th and 18th low phases when enabled
  always @(negedge scl) begin
    if (mon_on && in_txn) begin
      falls++;
      slave_drive = cur_ack && (falls % 9 == 0);
    end
  end

  always @(posedge sda) begin
    if (mon_on && in_txn && scl === 1'b1) begin
      in_txn = 1'b0;
      slave_drive = 1'b0;
      // The stop condition's own SCL rise is not a data bit
      i2c_bits = i2c_bits >> 1;
      n_bits--;
      if (txn_q.size() == 0) begin
        unexpected("i2c_txn");
      end else begin
        txn_exp = txn_q.pop_front();
        check("i2c_bit_count", 32'(n_bits), txn_exp ? 32'd18 : 32'd9);
        check("i2c_bits", i2c_bits,
              txn_exp ? {14'd0, 8'hAA, 1'b0, 8'hAA, 1'b0} : {23'd0, 8'hAA, 1'b1});
      end
    end
  end

  initial begin
    #(ClkPeriod * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          k, gap;
  logic [7:0]  rb;
  bit          rstop, rack;
  bit          drained;

  initial begin
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_led", 32'(led), 32'd0);
    check("reset_led_control", 32'(led_control), 32'd0);
    check("reset_uart_txd", 32'(uart_txd), 32'd1);
    check("reset_scl", 32'(scl), 32'd1);
    check("reset_sda", 32'(sda), 32'd1);
    mon_on = 1'b1;
    repeat (5) @(negedge clk);

    // Directed: feed with ACK, stop, bad-stop byte, feed with NACK
    send_byte(8'h46, 1'b1, 1'b1);
    repeat (AckTxnLen) @(negedge clk);
    send_byte(8'h53, 1'b1, 1'b0);
    send_byte(8'h41, 1'b0, 1'b0);
    send_byte(8'h46, 1'b1, 1'b0);
    repeat (NackTxnLen) @(negedge clk);

    // Randomized traffic, including back-to-back frames
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      if (k < 3) begin
        rb = 8'h46;
      end else if (k < 5) begin
        rb = 8'h53;
      end else begin
        rb = 8'($urandom_range(0, 255));
        if (rb == 8'h46 || rb == 8'h53) rb = rb ^ 8'h01;
      end
      rstop = ($urandom_range(0, 9) != 0);
      rack = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) begin
        gap = $urandom_range(1, 3 * Div);
        repeat (gap) @(negedge clk);
      end
      send_byte(rb, rstop, rack);
    end

    drained = 1'b0;
    for (int t = 0; t < 4000 && !drained; t++) begin
      @(negedge clk);
      drained = (echo_q.size() == 0) && (led_exp_q.size() == 0) && (txn_q.size() == 0)
                && !in_txn && (cyc > i2c_free_at + Margin);
    end
    if (!drained) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: echo=%0d led=%0d i2c=%0d still pending",
               echo_q.size(), led_exp_q.size(), txn_q.size());
    end
    check("echo_queue_empty", 32'(echo_q.size()), 32'd0);
    check("i2c_queue_empty", 32'(txn_q.size()), 32'd0);

    // Reset while an echo and an I2C transaction are both in flight
    mon_on = 1'b0;
    send_byte(8'h46, 1'b1, 1'b0);
    send_byte(8'h41, 1'b1, 1'b0);
    repeat (Div * 5) @(negedge clk);
    check("pre_reset_led_control", 32'(led_control), 32'(m_ctrl));
    check("pre_reset_scl_low_or_txd_busy", 32'(scl & uart_txd), 32'd0);
    slave_drive = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_uart_txd", 32'(uart_txd), 32'd1);
    check("midreset_scl", 32'(scl), 32'd1);
    check("midreset_sda", 32'(sda), 32'd1);
    check("midreset_led_control", 32'(led_control), 32'd0);
    check("midreset_led", 32'(led), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3 * Div) @(negedge clk);
    check("post_reset_uart_txd", 32'(uart_txd), 32'd1);
    check("post_reset_scl", 32'(scl), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
